// File: rtl/ast_tensor_stream_sv.sv
// Streaming matrix multiply X = A*B with saturated, row-major output drain.
// Optional ReLU clamp on emitted results when TENSOR_RELU_EN is defined.
module ast_tensor_stream_sv #(
   parameter int DATAWIDTH = 14,
   parameter int SIZE      = 4,
   parameter int ACCWIDTH  = 2*DATAWIDTH+$clog2(SIZE)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cfg_valid,
   input  logic [$clog2(SIZE):0]  cfg_q,
   input  logic [$clog2(SIZE):0]  cfg_r,
   input  logic [$clog2(SIZE):0]  cfg_k,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_set,
   input  logic [DATAWIDTH-1:0]   in_data,
   input  logic                   start,
   input  logic                   keep_b,
   input  logic                   relu,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATAWIDTH-1:0]   out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int unsigned CW = $clog2(SIZE) + 1;
   localparam int unsigned NW = 2 * CW;
   localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int unsigned MW = (SIZE > 1) ? $clog2(SIZE*SIZE) : 1;
   localparam logic signed [ACCWIDTH-1:0] SAT_MAX = ACCWIDTH'((64'sd1 <<< (DATAWIDTH-1)) - 64'sd1);
   localparam logic signed [ACCWIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;
   state_t state, state_n;

   logic [CW-1:0] q_r, r_r, k_r, ci, cr, oi, oj;
   logic [NW-1:0] a_cnt, b_cnt, a_need, b_need, a_ptr, b_base;
   logic          keep_r, dims_ok, start_ok, accept, mac_last, go, done_n, err_n;
   logic signed [DATAWIDTH-1:0]   a_mem [SIZE*SIZE];
   logic signed [DATAWIDTH-1:0]   b_mem [SIZE*SIZE];
   logic signed [ACCWIDTH-1:0]    acc   [SIZE][SIZE];
   logic signed [2*DATAWIDTH-1:0] prod  [SIZE];
   logic        [DATAWIDTH-1:0]   drain_val;

   function automatic logic [DATAWIDTH-1:0] sat(input logic signed [ACCWIDTH-1:0] v);
      logic signed [ACCWIDTH-1:0] s;
      s = v;
      if (v > SAT_MAX)      s = SAT_MAX;
      else if (v < SAT_MIN) s = SAT_MIN;
      return DATAWIDTH'(s);
   endfunction

   assign a_need   = NW'(q_r) * NW'(r_r);
   assign b_need   = NW'(r_r) * NW'(k_r);
   assign dims_ok  = (q_r != '0) && (r_r != '0) && (k_r != '0) &&
                     (q_r <= CW'(SIZE)) && (r_r <= CW'(SIZE)) && (k_r <= CW'(SIZE));
   // A same-cycle cfg_valid clears the counters, so start cannot succeed with it.
   assign start_ok = !cfg_valid && dims_ok && (a_cnt == a_need) && (b_cnt == b_need);
   assign in_ready = (state == IDLE) && (in_set ? (b_cnt < b_need) : (a_cnt < a_need));
   assign accept   = in_valid && in_ready && !cfg_valid;
   assign mac_last = (a_ptr == a_need - NW'(1));

   // Next-state and control pulses
   always_comb begin
      state_n = state;
      go      = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (start_ok) begin
                  state_n = COMPUTE;
                  go      = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         COMPUTE: if (mac_last) state_n = DRAIN;
         DRAIN: begin
            if (out_valid && out_ready && out_last) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != IDLE);
         done  <= done_n;
         err   <= err_n;
      end
   end

   // One A element against one row of B per cycle
   always_comb begin
      for (int j = 0; j < SIZE; j++) begin
         prod[j] = a_mem[MW'(a_ptr)] * b_mem[MW'(b_base + NW'(j))];
      end
   end

   always_comb begin
      drain_val = sat(acc[IW'(oi)][IW'(oj)]);
`ifdef TENSOR_RELU_EN
      if (relu && drain_val[DATAWIDTH-1]) drain_val = '0;
`endif
   end

`ifndef TENSOR_RELU_EN
   logic unused_relu;
   assign unused_relu = relu;
`endif

   always_ff @(posedge clk) begin
      if (state == IDLE && accept) begin
         if (in_set) b_mem[MW'(b_cnt)] <= in_data;
         else        a_mem[MW'(a_cnt)] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r       <= '0;
         r_r       <= '0;
         k_r       <= '0;
         a_cnt     <= '0;
         b_cnt     <= '0;
         a_ptr     <= '0;
         b_base    <= '0;
         ci        <= '0;
         cr        <= '0;
         oi        <= '0;
         oj        <= '0;
         keep_r    <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
               acc[i][j] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cfg_valid) begin
                  q_r   <= cfg_q;
                  r_r   <= cfg_r;
                  k_r   <= cfg_k;
                  a_cnt <= '0;
                  if (!keep_r) b_cnt <= '0;
               end else if (accept) begin
                  if (in_set) b_cnt <= b_cnt + NW'(1);
                  else        a_cnt <= a_cnt + NW'(1);
               end
               if (go) begin
                  keep_r <= keep_b;
                  a_ptr  <= '0;
                  b_base <= '0;
                  ci     <= '0;
                  cr     <= '0;
                  oi     <= '0;
                  oj     <= '0;
                  for (int i = 0; i < SIZE; i++)
                     for (int j = 0; j < SIZE; j++)
                        acc[i][j] <= '0;
               end
            end
            COMPUTE: begin
               for (int j = 0; j < SIZE; j++) begin
                  if (CW'(j) < k_r)
                     acc[IW'(ci)][IW'(j)] <= acc[IW'(ci)][IW'(j)] + ACCWIDTH'(prod[j]);
               end
               a_ptr <= a_ptr + NW'(1);
               if (cr == r_r - CW'(1)) begin
                  cr     <= '0;
                  b_base <= '0;
                  ci     <= ci + CW'(1);
               end else begin
                  cr     <= cr + CW'(1);
                  b_base <= b_base + NW'(k_r);
               end
            end
            DRAIN: begin
               // Output register refills whenever empty or being consumed
               if (!out_valid || out_ready) begin
                  if (out_valid && out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     a_cnt     <= '0;
                     if (!keep_r) b_cnt <= '0;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= drain_val;
                     out_last  <= (oi == q_r - CW'(1)) && (oj == k_r - CW'(1));
                     if (oj == k_r - CW'(1)) begin
                        oj <= '0;
                        oi <= oi + CW'(1);
                     end else begin
                        oj <= oj + CW'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ast_tensor_stream_sv.sv
// Directed self-checking bench for ast_tensor_stream_sv (DATAWIDTH=14, SIZE=4).
module tb_ast_tensor_stream_sv;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_valid;
   logic [2:0]  cfg_q, cfg_r, cfg_k;
   logic        in_valid, in_ready, in_set;
   logic [13:0] in_data;
   logic        start, keep_b, relu;
   logic        out_valid, out_ready, out_last;
   logic [13:0] out_data;
   logic        busy, done, err;

   int checks   = 0;
   int failures = 0;
   int got_d [16];
   logic got_l [16];
   int got_n;

   ast_tensor_stream_sv #(.DATAWIDTH(14), .SIZE(4)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid),
      .cfg_q(cfg_q), .cfg_r(cfg_r), .cfg_k(cfg_k),
      .in_valid(in_valid), .in_ready(in_ready), .in_set(in_set), .in_data(in_data),
      .start(start), .keep_b(keep_b), .relu(relu),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int q, input int r, input int k);
      cfg_valid = 1'b1; cfg_q = 3'(q); cfg_r = 3'(r); cfg_k = 3'(k);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic push(input logic s, input int v);
      in_valid = 1'b1; in_set = s; in_data = 14'(v);
      step();
      in_valid = 1'b0;
   endtask

   task automatic push4(input logic s, input int a, input int b, input int c, input int d);
      push(s, a); push(s, b); push(s, c); push(s, d);
   endtask

   task automatic do_start(input logic kb);
      start = 1'b1; keep_b = kb;
      step();
      start = 1'b0; keep_b = 1'b0;
   endtask

   // Collects up to n outputs with out_ready held high; returns one sample after the final accept
   task automatic drain(input int n);
      got_n = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && got_n < n; c++) begin
         if (out_valid) begin
            got_d[got_n] = int'($signed(out_data));
            got_l[got_n] = out_last;
            got_n++;
         end
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      checks++;
      if ({out_valid, out_last, busy, done, err, in_ready} !== 6'b0 || out_data !== 14'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b data=%0d exp=000000 data=0",
                  {out_valid, out_last, busy, done, err, in_ready}, out_data);
      end
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int expv [4] = '{19, 22, 43, 50};
      int first_valid;
      cfg(2, 2, 2);
      push4(1'b0, 1, 2, 3, 4);
      in_set = 1'b0; #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL basic_a_full_ready got=%b exp=0", in_ready);
      end
      in_set = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL basic_b_empty_ready got=%b exp=1", in_ready);
      end
      step();
      push4(1'b1, 5, 6, 7, 8);
      do_start(1'b0);
      checks++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         failures++; $display("FAIL basic_busy got=%b err=%b exp busy=1 err=0", busy, err);
      end
      first_valid = -1;
      for (int c = 0; c < 20 && first_valid < 0; c++) begin
         if (out_valid) first_valid = c;
         else step();
      end
      checks++;
      if (first_valid < 4) begin
         failures++; $display("FAIL basic_compute_len got=%0d exp>=4", first_valid);
      end
      drain(4);
      checks++;
      if (got_n !== 4) begin
         failures++; $display("FAIL basic_count got=%0d exp=4", got_n);
      end
      for (int i = 0; i < got_n; i++) begin
         checks++;
         if (got_d[i] !== expv[i] || got_l[i] !== (i == 3)) begin
            failures++;
            $display("FAIL basic_out%0d got=%0d last=%b exp=%0d last=%b", i, got_d[i], got_l[i], expv[i], i == 3);
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done, busy);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL basic_done_pulse got=%b exp=0", done);
      end
   endtask

   task automatic test_stall();
      int expv [3] = '{-26, -28, -30};
      logic [13:0] pd;
      logic pl, prev_stall;
      cfg(1, 4, 3);
      push4(1'b0, 1, -2, 3, -4);
      push4(1'b1, 1, 2, 3, 4);
      push4(1'b1, 5, 6, 7, 8);
      push4(1'b1, 9, 10, 11, 12);
      do_start(1'b0);
      got_n = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0;
      for (int c = 0; c < 300 && got_n < 3; c++) begin
         out_ready = (c % 2 == 1);
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
               failures++;
               $display("FAIL stall_hold got=%0d last=%b exp=%0d last=%b", out_data, out_last, pd, pl);
            end
         end
         if (out_valid && out_ready) begin
            got_d[got_n] = int'($signed(out_data));
            got_l[got_n] = out_last;
            got_n++;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data; pl = out_last;
         step();
      end
      out_ready = 1'b0;
      checks++;
      if (got_n !== 3) begin
         failures++; $display("FAIL stall_count got=%0d exp=3", got_n);
      end
      for (int i = 0; i < got_n; i++) begin
         checks++;
         if (got_d[i] !== expv[i] || got_l[i] !== (i == 2)) begin
            failures++;
            $display("FAIL stall_out%0d got=%0d last=%b exp=%0d last=%b", i, got_d[i], got_l[i], expv[i], i == 2);
         end
      end
      checks++;
      if (done !== 1'b1) begin
         failures++; $display("FAIL stall_done got=%b exp=1", done);
      end
      step();
   endtask

   task automatic run_1x1(input int a, input int b, input logic rl, input int expv, input string name);
      cfg(1, 1, 1);
      push(1'b0, a);
      push(1'b1, b);
      relu = rl;
      do_start(1'b0);
      drain(1);
      relu = 1'b0;
      checks++;
      if (got_n !== 1 || got_d[0] !== expv || got_l[0] !== 1'b1) begin
         failures++;
         $display("FAIL %s got n=%0d data=%0d last=%b exp n=1 data=%0d last=1", name, got_n, got_d[0], got_l[0], expv);
      end
      step();
   endtask

   task automatic test_saturation();
      run_1x1(8191, 8191, 1'b0, 8191, "sat_pos");
      run_1x1(-8192, 8191, 1'b0, -8192, "sat_neg");
`ifdef TENSOR_RELU_EN
      run_1x1(-8192, 8191, 1'b1, 0, "relu_clamp");
`else
      run_1x1(-8192, 8191, 1'b1, -8192, "relu_ignored");
`endif
      run_1x1(-3, 5, 1'b0, -15, "small_neg");
   endtask

   task automatic check_err(input string name);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL %s got err=%b busy=%b exp err=1 busy=0", name, err, busy);
      end
      step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL %s_pulse got err=%b busy=%b exp err=0 busy=0", name, err, busy);
      end
   endtask

   task automatic test_errors();
      cfg(1, 2, 2);
      push(1'b0, 1); push(1'b0, 2);
      push(1'b1, 1); push(1'b1, 2); push(1'b1, 3);
      do_start(1'b0);
      check_err("err_b_short");
      cfg(1, 2, 0);
      in_set = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL err_k0_ready got=%b exp=0", in_ready);
      end
      step();
      do_start(1'b0);
      check_err("err_k0");
      cfg(1, 1, 1);
      push(1'b0, 2); push(1'b1, 3);
      cfg_valid = 1'b1; cfg_q = 3'd1; cfg_r = 3'd1; cfg_k = 3'd1;
      start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      check_err("err_cfg_and_start");
   endtask

   task automatic test_keep_b();
      int exp1 [4] = '{19, 22, 43, 50};
      int exp2 [4] = '{5, 6, 7, 8};
      cfg(2, 2, 2);
      push4(1'b0, 1, 2, 3, 4);
      push4(1'b1, 5, 6, 7, 8);
      do_start(1'b1);
      drain(4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_n !== 4 || got_d[i] !== exp1[i]) begin
            failures++; $display("FAIL keep_run1_out%0d got=%0d exp=%0d", i, got_d[i], exp1[i]);
         end
      end
      step();
      in_set = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL keep_b_retained_ready got=%b exp=0", in_ready);
      end
      step();
      push4(1'b0, 1, 0, 0, 1);
      do_start(1'b0);
      drain(4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_n !== 4 || got_d[i] !== exp2[i] || got_l[i] !== (i == 3)) begin
            failures++; $display("FAIL keep_run2_out%0d got=%0d exp=%0d", i, got_d[i], exp2[i]);
         end
      end
      step();
      push4(1'b0, 1, 0, 0, 1);
      do_start(1'b0);
      check_err("keep_cleared_err");
   endtask

   task automatic test_reset_mid_drain();
      int seen;
      cfg(2, 2, 2);
      push4(1'b0, 1, 2, 3, 4);
      push4(1'b1, 5, 6, 7, 8);
      do_start(1'b1);
      out_ready = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         if (out_valid) seen = 1;
         else step();
      end
      checks++;
      if (seen !== 1) begin
         failures++; $display("FAIL rst_reach_drain got=%0d exp=1", seen);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_last, busy, done, err, in_ready} !== 6'b0 || out_data !== 14'd0) begin
         failures++;
         $display("FAIL rst_mid_drain got=%b data=%0d exp=000000 data=0",
                  {out_valid, out_last, busy, done, err, in_ready}, out_data);
      end
      step();
      reset_n = 1'b1;
      step();
      do_start(1'b0);
      check_err("rst_then_start_err");
   endtask

   initial begin
      reset_n = 1'b0; cfg_valid = 1'b0; cfg_q = '0; cfg_r = '0; cfg_k = '0;
      in_valid = 1'b0; in_set = 1'b0; in_data = '0;
      start = 1'b0; keep_b = 1'b0; relu = 1'b0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_saturation();
      test_errors();
      test_keep_b();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ast_tensor_stream_sv.md
AST_TENSOR_STREAM_SV -- requirements
Module: ast_tensor_stream_sv

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 14, signed element width of A, B and X.
REQ-002 SHALL have parameter SIZE, default 4, maximum value of each matrix dimension (Q, R, K).
REQ-003 SHALL have parameter ACCWIDTH, default 2*DATAWIDTH+$clog2(SIZE), internal accumulator width.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: cfg_valid in 1, dimension latch strobe; cfg_q, cfg_r, cfg_k in $clog2(SIZE)+1, dimensions of A (QxR) and B (RxK).
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; in_set in 1 (0 = A, 1 = B); in_data in DATAWIDTH, row-major element.
REQ-007 SHALL have ports: start in 1; keep_b in 1, retain B after completion; relu in 1, ReLU enable.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_data out DATAWIDTH; out_last out 1, final element.
REQ-009 SHALL have ports: busy out 1; done out 1, one-cycle pulse; err out 1, one-cycle pulse.

Function
REQ-010 SHALL implement FSM IDLE -> COMPUTE -> DRAIN -> IDLE.
REQ-011 SHALL latch cfg_q/r/k on cfg_valid in IDLE, clear the A load counter, and clear the B load counter unless B is retained (REQ-020). cfg_valid outside IDLE SHALL be ignored.
REQ-012 SHALL accept an element when in_valid & in_ready. in_ready = IDLE & (in_set ? B count < R*K : A count < Q*R).
REQ-013 SHALL store A[i][r] at A counter i*R+r and B[r][j] at B counter r*K+j, incrementing the selected counter per accepted element.
REQ-014 SHALL accept start in IDLE only when A count == Q*R, B count == R*K and 1 <= Q,R,K <= SIZE. Otherwise SHALL pulse err for one cycle and stay IDLE.
REQ-015 In COMPUTE, SHALL spend one cycle per (i, r), i in 0..Q-1, r in 0..R-1, computing acc[i][j] += A[i][r]*B[r][j] for all j < K in parallel. COMPUTE SHALL last exactly Q*R cycles.
REQ-016 SHALL use signed two's-complement products of 2*DATAWIDTH bits, sign-extended into ACCWIDTH accumulators cleared on entry to COMPUTE.
REQ-017 SHALL saturate each result to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1] when it is emitted.
REQ-018 In DRAIN, SHALL emit X row-major, Q*K elements, one per out_valid & out_ready.
  - out_data and out_last SHALL hold stable while out_valid & !out_ready.
  - out_last SHALL be high only with element (Q-1, K-1).
REQ-019 SHALL pulse done in the cycle after the last element is accepted, and return to IDLE in that cycle.
REQ-020 On return to IDLE, SHALL clear the A count. SHALL clear the B count unless keep_b was 1 when start was accepted; in that case B stays loaded for the next start.
REQ-021 busy SHALL be 1 in COMPUTE and DRAIN, else 0. start during busy SHALL be ignored without err.
REQ-022 Same-cycle cfg_valid and start in IDLE: cfg_valid SHALL take effect and start SHALL be evaluated against the cleared counters, giving err.

Reset
REQ-023 reset_n low SHALL asynchronously force the following, including mid-COMPUTE or mid-DRAIN; the aborted result SHALL be discarded:
  - state to IDLE; all counters, dimensions and accumulators to 0;
  - in_ready, out_valid, out_last, busy, done, err to 0; out_data to 0.

Configuration
REQ-024 With TENSOR_RELU_EN defined, SHALL clamp negative saturated results to 0 when relu == 1. Without it, relu SHALL be ignored and results emitted as saturated.

Verification
REQ-025 Load Q=R=K=2 with A=[1,2,3,4], B=[5,6,7,8], start -> COMPUTE 4 cycles, then out 19, 22, 43, 50, out_last on 50, done 1 cycle later.
REQ-026 Q=1, R=4, K=3, out_ready toggling every cycle -> 3 outputs correct, each held stable while stalled, out_last only on third.
REQ-027 DATAWIDTH=14, A=[8191], B=[8191], 1x1x1 -> out_data 8191 (saturated). A=[-8192], B=[8191] -> -8192. With TENSOR_RELU_EN and relu=1 -> 0.
REQ-028 start with B count 3 of required 4, and start with cfg_k=0 -> err pulse each time, busy stays 0.
REQ-029 keep_b=1 run, then reload only A and start -> correct result using retained B. keep_b=0 -> next start without reloading B gives err.
REQ-030 reset_n low for 1 cycle mid-DRAIN -> all outputs 0 immediately, state IDLE, next start without reload gives err.
